bcd2bin_serial: RTL and testbench

- Serial BCD-to-binary converter; the inverse of the team's serial binary-to-BCD converter.
- Uses the reverse double-dabble method: shift right, then subtract 3 from any digit >= 8. Takes one shift per output bit.
- Sits behind decimal entry paths (keypad/ASCII-decimal parsers) and feeds binary datapaths.
- Flags inputs containing non-decimal digits, and values that do not fit the binary width.

---
 rtl/bcd2bin_serial_pkg.sv | 19 +
 rtl/bcd2bin_serial_if.sv | 23 ++
 rtl/bcd2bin_serial_digit_rev.sv | 31 +++
 rtl/bcd2bin_serial.sv | 72 +++++++
 tb/tb_bcd2bin_serial.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bcd2bin_serial_pkg.sv
// Shared helpers for the serial BCD-to-binary converter.
// Digit correction, digit validity and counter sizing.
package bcd2bin_serial_pkg;

   // Counter must hold the full shift count, not just count-1.
   function automatic int cnt_width(input int bits);
      return $clog2(bits) + 1;
   endfunction

   // Reverse double-dabble correction applied after each right shift.
   function automatic logic [3:0] digit_fix(input logic [3:0] d);
      return (d >= 4'd8) ? d - 4'd3 : d;
   endfunction

   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'd9;
   endfunction

endpackage

// File: rtl/bcd2bin_serial_if.sv
// Request/result bundle for the serial BCD-to-binary converter.
// The requester drives start/bcd_in; the converter returns the result.
interface bcd2bin_serial_if #(
   parameter int BINARY_BITS = 16,
   parameter int BCD_DIGITS  = 5
);
   logic                      start;
   logic [4*BCD_DIGITS-1:0]   bcd_in;
   logic [BINARY_BITS-1:0]    binary_out;
   logic                      done;
   logic                      overflow;
   logic                      invalid;

   modport master (
      output start, bcd_in,
      input  binary_out, done, overflow, invalid
   );

   modport slave (
      input  start, bcd_in,
      output binary_out, done, overflow, invalid
   );
endinterface

// File: rtl/bcd2bin_serial_digit_rev.sv
// One BCD digit of the reverse double-dabble shift chain.
// Shifts right by one, pulling ser_in into bit 3, then corrects.
module bcd_digit_rev
   import bcd2bin_serial_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       init,
   input  logic [3:0] load_val,
   input  logic       ser_in,
   output logic       ser_out,
   output logic [3:0] digit
);

   logic [3:0] shifted;

   assign shifted = {ser_in, digit[3:1]};
   assign ser_out = digit[0];

   // Load on init, otherwise shift-then-subtract-3 when enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         digit <= '0;
      else if (init)
         digit <= load_val;
      else if (ce)
         digit <= digit_fix(shifted);
   end

endmodule

// File: rtl/bcd2bin_serial.sv
// Serial BCD-to-binary converter, one binary bit per clock.
// Flags non-decimal digits and results wider than BINARY_BITS.
module bcd2bin_serial
   import bcd2bin_serial_pkg::*;
#(
   parameter int BINARY_BITS = 16,
   parameter int BCD_DIGITS  = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   bcd2bin_serial_if.slave   bus
);

   localparam int CW = cnt_width(BINARY_BITS);

   logic [BINARY_BITS-1:0]  binary_shift;
   logic [CW-1:0]           count;
   logic                    inv_q;
   logic                    inv_d;
   logic                    ce;
   logic [4*BCD_DIGITS-1:0] bcd;
   logic [BCD_DIGITS:0]     ser;

   assign ce = !bus.start && (count != '0);
   assign ser[BCD_DIGITS] = 1'b0;

   genvar j;
   generate
      for (j = 0; j < BCD_DIGITS; j++) begin : g_dig
         bcd_digit_rev u_dig (
            .clock    (clock),
            .reset_n  (reset_n),
            .ce       (ce),
            .init     (bus.start),
            .load_val (bus.bcd_in[4*j +: 4]),
            .ser_in   (ser[j+1]),
            .ser_out  (ser[j]),
            .digit    (bcd[4*j +: 4])
         );
      end
   endgenerate

   // Any non-decimal digit in the operand being loaded.
   always_comb begin
      inv_d = 1'b0;
      for (int k = 0; k < BCD_DIGITS; k++)
         inv_d = inv_d | digit_bad(bus.bcd_in[4*k +: 4]);
   end

   // Shift counter, collected binary bits and the invalid flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         binary_shift <= '0;
         count        <= '0;
         inv_q        <= 1'b0;
      end else if (bus.start) begin
         binary_shift <= '0;
         count        <= CW'(BINARY_BITS);
         inv_q        <= inv_d;
      end else if (ce) begin
         binary_shift <= {ser[0], binary_shift[BINARY_BITS-1:1]};
         count        <= count - 1'b1;
      end
   end

   // Residue left in the BCD chain means the value did not fit.
   assign bus.done       = (count == '0);
   assign bus.overflow   = bus.done & (bcd != '0);
   assign bus.invalid    = inv_q;
   assign bus.binary_out = inv_q ? '0 : binary_shift;

endmodule

// File: tb/tb_bcd2bin_serial.sv
// Self-checking bench for bcd2bin_serial.
// Random and directed operands checked against a decimal model.
module tb_bcd2bin_serial;

   localparam int BB = 16;
   localparam int BD = 5;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   bcd2bin_serial_if #(.BINARY_BITS(BB), .BCD_DIGITS(BD)) bus ();

   bcd2bin_serial #(.BINARY_BITS(BB), .BCD_DIGITS(BD)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic longint bcd_val(input logic [4*BD-1:0] b);
      longint v = 0;
      for (int i = BD - 1; i >= 0; i--)
         v = v * 10 + longint'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic logic bcd_bad(input logic [4*BD-1:0] b);
      logic r = 1'b0;
      for (int i = 0; i < BD; i++)
         if (b[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input longint act,
                        input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: remaining cycles plus the decimal result.
   int          m_cnt;
   logic [BB-1:0] m_out;
   logic        m_ovf, m_inv, m_ovf_known;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt <= 0;
         m_out <= '0;
         m_ovf <= 1'b0;
         m_inv <= 1'b0;
         m_ovf_known <= 1'b1;
      end else if (bus.start) begin
         m_cnt <= BB;
         m_inv <= bcd_bad(bus.bcd_in);
         m_ovf_known <= !bcd_bad(bus.bcd_in);
         m_ovf <= bcd_val(bus.bcd_in) >= (longint'(1) << BB);
         m_out <= bcd_bad(bus.bcd_in) ? '0
                  : BB'(bcd_val(bus.bcd_in) % (longint'(1) << BB));
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clock) begin
      if (reset_n) begin
         check("done", bus.done, m_cnt == 0);
         if (bus.done && m_cnt == 0) begin
            check("binary_out", bus.binary_out, m_out);
            check("invalid", bus.invalid, m_inv);
            if (m_ovf_known) check("overflow", bus.overflow, m_ovf);
         end
      end
   end

   // One conversion: checks done timing and optional literal results.
   task automatic convert(input logic [4*BD-1:0] v, input logic lit,
                          input logic [BB-1:0] e_out, input logic e_ovf,
                          input logic e_inv);
      int n;
      @(negedge clock);
      bus.start = 1'b1;
      bus.bcd_in = v;
      @(negedge clock);
      bus.start = 1'b0;
      check("done_fall", bus.done, 0);
      n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("latency", n, BB);
      if (lit) begin
         check("lit_out", bus.binary_out, e_out);
         check("lit_inv", bus.invalid, e_inv);
         if (!e_inv) check("lit_ovf", bus.overflow, e_ovf);
      end
   endtask

   initial begin
      logic [4*BD-1:0] r;
      bus.start = 1'b0;
      bus.bcd_in = '0;
      #1;
      check("rst_done", bus.done, 1);
      check("rst_out", bus.binary_out, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_inv", bus.invalid, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      convert(20'h65535, 1, 16'hFFFF, 0, 0);
      convert(20'h00010, 1, 16'h000A, 0, 0);
      convert(20'h00000, 1, 16'h0000, 0, 0);
      convert(20'h65536, 1, 16'h0000, 1, 0);
      convert(20'h99999, 1, 16'h869F, 1, 0);
      convert(20'h0000A, 1, 16'h0000, 0, 1);
      convert(20'h00042, 1, 16'h002A, 0, 0);

      // Restart while busy.
      @(negedge clock);
      bus.start = 1'b1;
      bus.bcd_in = 20'h12345;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (4) @(negedge clock);
      convert(20'h00007, 1, 16'h0007, 0, 0);

      // Start held high keeps reloading.
      @(negedge clock);
      bus.start = 1'b1;
      bus.bcd_in = 20'h00123;
      repeat (10) begin
         @(negedge clock);
         check("hold_done", bus.done, 0);
      end
      bus.start = 1'b0;
      repeat (20) @(negedge clock);
      check("hold_out", bus.binary_out, 16'd123);

      // Reset in the middle of a conversion.
      @(negedge clock);
      bus.start = 1'b1;
      bus.bcd_in = 20'h98765;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_done", bus.done, 1);
      check("mid_rst_out", bus.binary_out, 0);
      check("mid_rst_ovf", bus.overflow, 0);
      check("mid_rst_inv", bus.invalid, 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Random decimal sweep, model checks results at done.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < BD; i++)
            r[4*i +: 4] = 4'($urandom_range(0, 9));
         convert(r, 0, '0, 0, 0);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
